axi_mem_slave: RTL and testbench
================================

// Module: axi_mem_slave
// PURPOSE
// Parametrised AXI4 memory slave; successor to the fixed 32-bit, 4-beat axi_slave.
// - Generic data/address/ID width and memory depth.
// - FIXED, INCR and WRAP bursts; WSTRB byte enables; SLVERR on errors.
// - Independent read and write engines.
// - Used as a bus-attached RAM model behind axi_master and the interconnect.
// PARAMETERS
// DATA_W  32  data bus width in bits; power of 2, >= 8; BYTES = DATA_W/8
// ADDR_W  32  byte address width
// ID_W    4   transaction ID width
// DEPTH   256 memory depth in DATA_W words; power of 2
// PORTS
// aclk             in  1       clock, rising edge
// areset           in  1       asynchronous active-high reset
// s_awid/awaddr    in  ID_W/ADDR_W  write address and ID
// s_awlen/awburst  in  8/2     beats-1; burst type (00 FIXED, 01 INCR, 10 WRAP)
// s_awvalid/awready  in/out  1   AW handshake
// s_wdata/wstrb    in  DATA_W/BYTES  write data and byte enables
// s_wlast          in  1       last write beat flag
// s_wvalid/wready  in/out  1   W handshake
// s_bid/bresp      out ID_W/2  write response ID and status
// s_bvalid/bready  out/in  1   B handshake
// s_arid/araddr/arlen/arburst  in  ID_W/ADDR_W/8/2  read address channel
// s_arvalid/arready  in/out  1  AR handshake
// s_rid/rdata/rresp  out ID_W/DATA_W/2  read data channel
// s_rlast          out 1       last read beat flag
// s_rvalid/rready  out/in  1   R handshake
// BEHAVIOUR
// Reset: async on areset=1.
// - awready=arready=1, wready=bvalid=rvalid=rlast=0.
// - bresp=rresp=0, bid=rid=rdata=0; both FSMs IDLE.
// - Memory contents are not reset.
// - Reset mid-burst abandons the burst; beats already written remain.
// AxSIZE is fixed at log2(BYTES); there is no size port.
// Word index = addr[ADDR_W-1:log2(BYTES)]; beat is out of range if index >= DEPTH.
// Beat address step:
// - FIXED: no change.
// - INCR: +BYTES, no 4KB check.
// - WRAP: +BYTES, wraps within the (len+1)*BYTES aligned window.
// Illegal burst:
// - burst=2'b11, or WRAP with len not in {1,3,7,15}.
// - Whole burst is processed as errored: no memory update, all beats SLVERR.
// Write FSM:
// - W_IDLE: awready=1. AW handshake latches id/addr/len/burst, clears beat counter and err flag.
//   Next state W_DATA, awready=0, wready=1 next cycle.
// - W_DATA: on each W handshake, bytes with wstrb[i]=1 are written.
//   An out-of-range beat is dropped and sets err.
//   wlast must equal (beat==len); any mismatch sets err.
//   The burst always terminates at beat len; wlast never ends a burst early.
//   On the final beat: wready=0, bvalid=1, bid=latched id, bresp = err ? 2'b10 : 2'b00. Next state W_RESP.
// - W_RESP: bvalid held until bready. Then W_IDLE, awready=1 next cycle.
// - W beats arriving before AW are not accepted (wready=0 outside W_DATA).
// Read FSM:
// - R_IDLE: arready=1. AR handshake latches the request; next state R_DATA.
//   First rvalid is asserted 1 cycle after the handshake (registered memory read).
// - R_DATA: rdata/rresp/rlast/rid are registered.
//   Held stable while rvalid && !rready.
//   Advance to the next beat on rvalid && rready, with no bubble between beats.
//   Out-of-range or illegal beat: rdata=0, rresp=2'b10. Otherwise rresp=2'b00.
//   rlast=1 on beat len. Its handshake returns to R_IDLE; arready=1 the next cycle.
// Read and write engines run concurrently.
// - Same-word write and read in one cycle: the read returns old data.
// - A write is visible to reads from the next cycle.
// Throughput: a len=N burst occupies N+1 data cycles plus 1 response cycle (write).
//   Only one outstanding transaction per direction.
// TESTING
// 1 INCR write awaddr=0x10, len=3, data 0xdeadbeef+i, strb=0xF
//   -> bresp=00, bid=awid; words 4..7 = 0xdeadbeef..0xdeadbef2.
// 2 INCR read of the same burst with rready toggling 1/0
//   -> 4 beats 0xdeadbeef+i, rlast only on beat 3, rdata stable while stalled.
// 3 WRAP len=3, addr=0x18 (window 0x10-0x1F), then write strb=0x3 data 0xFFFFFFFF to 0x10
//   -> write order words 6,7,4,5; word 4 = 0x????FFFF, upper bytes unchanged.
// 4 FIXED write len=2 to addr 0x20, data 1,2,3 -> word 8 = 3; bresp=00.
// 5 INCR read at word DEPTH-2, len=3
//   -> beats 0,1 rresp=00; beats 2,3 rresp=10 with rdata=0.
//   Write with burst=2'b11 -> bresp=10, memory untouched.
// 6 areset pulse mid write burst (after beat 1 of len=3)
//   -> all outputs at reset values; the next AW is accepted and completes with bresp=00.

Source files
------------

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: independent read and write burst engines over a byte-enabled
// word RAM, with FIXED/INCR/WRAP addressing and SLVERR on illegal or out-of-range beats.
module axi_mem_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 256
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ID_W-1:0]       s_awid,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic [7:0]            s_awlen,
    input  logic [1:0]            s_awburst,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_wlast,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [ID_W-1:0]       s_bid,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ID_W-1:0]       s_arid,
    input  logic [ADDR_W-1:0]     s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic [1:0]            s_arburst,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [ID_W-1:0]       s_rid,
    output logic [DATA_W-1:0]     s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic                  s_rvalid,
    input  logic                  s_rready
);
    localparam int BYTES = DATA_W / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    function automatic logic burst_illegal(input logic [1:0] burst, input logic [7:0] len);
        return (burst == 2'b11) ||
               (burst == BURST_WRAP && len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15);
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] idx;
        idx = addr >> LSB;
        return idx < ADDR_W'(DEPTH);
    endfunction

    // WRAP keeps the upper address bits of the (len+1)*BYTES window and wraps the low ones.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [1:0] burst,
                                                    input logic [7:0] len);
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] mask;
        logic [ADDR_W-1:0] res;
        step = addr + ADDR_W'(BYTES);
        mask = ((ADDR_W'(len) + 1'b1) << LSB) - 1'b1;
        if (burst == BURST_FIXED)
            res = addr;
        else if (burst == BURST_WRAP)
            res = (addr & ~mask) | (step & mask);
        else
            res = step;
        return res;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        w_state;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len;
    logic [1:0]        w_burst;
    logic [7:0]        w_beat;
    logic              w_err;
    logic              w_illegal;
    logic              aw_hs, w_hs, w_last_beat, w_err_nxt, mem_we;

    always_comb begin
        aw_hs       = s_awvalid && s_awready;
        w_hs        = s_wvalid && s_wready;
        w_last_beat = (w_beat == w_len);
        w_err_nxt   = w_err || !in_range(w_addr) || (s_wlast != w_last_beat);
        mem_we      = w_hs && !w_illegal && in_range(w_addr);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state   <= W_IDLE;
            s_awready <= 1'b1;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bid     <= '0;
            s_bresp   <= RESP_OKAY;
            w_beat    <= 8'd0;
            w_err     <= 1'b0;
            w_illegal <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (aw_hs) begin
                    w_state   <= W_DATA;
                    s_awready <= 1'b0;
                    s_wready  <= 1'b1;
                    w_beat    <= 8'd0;
                    w_err     <= burst_illegal(s_awburst, s_awlen);
                    w_illegal <= burst_illegal(s_awburst, s_awlen);
                end
                W_DATA: if (w_hs) begin
                    w_err <= w_err_nxt;
                    // wlast never ends a burst early; only the beat count does.
                    if (w_last_beat) begin
                        w_state  <= W_RESP;
                        s_wready <= 1'b0;
                        s_bvalid <= 1'b1;
                        s_bid    <= w_id;
                        s_bresp  <= w_err_nxt ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        w_beat <= w_beat + 8'd1;
                    end
                end
                W_RESP: if (s_bready) begin
                    w_state   <= W_IDLE;
                    s_bvalid  <= 1'b0;
                    s_awready <= 1'b1;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (aw_hs) begin
            w_id    <= s_awid;
            w_addr  <= s_awaddr;
            w_len   <= s_awlen;
            w_burst <= s_awburst;
        end else if (w_hs) begin
            w_addr <= next_addr(w_addr, w_burst, w_len);
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < BYTES; i++)
                if (s_wstrb[i])
                    mem[w_addr[LSB +: IDX_W]][i*8 +: 8] <= s_wdata[i*8 +: 8];
        end
    end

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [1:0]        r_burst;
    logic [7:0]        r_beat;
    logic              r_illegal;
    logic              ar_hs, r_adv, r_fetch, r_fetch_err, r_fetch_last, r_fetch_illegal;
    logic [ADDR_W-1:0] r_fetch_addr;

    // A fetch happens on the AR handshake (beat 0) or when the current beat is taken.
    always_comb begin
        ar_hs           = s_arvalid && s_arready;
        r_adv           = (r_state == R_DATA) && s_rvalid && s_rready && !s_rlast;
        r_fetch         = ar_hs || r_adv;
        r_fetch_addr    = ar_hs ? s_araddr : next_addr(r_addr, r_burst, r_len);
        r_fetch_illegal = ar_hs ? burst_illegal(s_arburst, s_arlen) : r_illegal;
        r_fetch_err     = r_fetch_illegal || !in_range(r_fetch_addr);
        r_fetch_last    = ar_hs ? (s_arlen == 8'd0) : (r_beat + 8'd1 == r_len);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= R_IDLE;
            s_arready <= 1'b1;
            s_rvalid  <= 1'b0;
            s_rlast   <= 1'b0;
            s_rresp   <= RESP_OKAY;
            s_rid     <= '0;
            s_rdata   <= '0;
            r_beat    <= 8'd0;
            r_illegal <= 1'b0;
        end else if (r_fetch) begin
            s_rvalid <= 1'b1;
            s_rdata  <= r_fetch_err ? '0 : mem[r_fetch_addr[LSB +: IDX_W]];
            s_rresp  <= r_fetch_err ? RESP_SLVERR : RESP_OKAY;
            s_rlast  <= r_fetch_last;
            if (ar_hs) begin
                r_state   <= R_DATA;
                s_arready <= 1'b0;
                s_rid     <= s_arid;
                r_beat    <= 8'd0;
                r_illegal <= r_fetch_illegal;
            end else begin
                r_beat <= r_beat + 8'd1;
            end
        end else if (s_rvalid && s_rready && s_rlast) begin
            r_state   <= R_IDLE;
            s_rvalid  <= 1'b0;
            s_rlast   <= 1'b0;
            s_arready <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (ar_hs) begin
            r_addr  <= s_araddr;
            r_len   <= s_arlen;
            r_burst <= s_arburst;
        end else if (r_adv) begin
            r_addr <= r_fetch_addr;
        end
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Bench for axi_mem_slave: directed and random bursts against a word-array reference
// model; expected B/R responses are queued at issue and popped by a separate monitor.
module tb_axi_mem_slave;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int DEPTH  = 256;

    logic              aclk = 1'b0;
    logic              areset = 1'b0;
    logic [ID_W-1:0]   s_awid = '0;
    logic [ADDR_W-1:0] s_awaddr = '0;
    logic [7:0]        s_awlen = '0;
    logic [1:0]        s_awburst = '0;
    logic              s_awvalid = 1'b0;
    logic              s_awready;
    logic [DATA_W-1:0] s_wdata = '0;
    logic [3:0]        s_wstrb = '0;
    logic              s_wlast = 1'b0;
    logic              s_wvalid = 1'b0;
    logic              s_wready;
    logic [ID_W-1:0]   s_bid;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic [ID_W-1:0]   s_arid = '0;
    logic [ADDR_W-1:0] s_araddr = '0;
    logic [7:0]        s_arlen = '0;
    logic [1:0]        s_arburst = '0;
    logic              s_arvalid = 1'b0;
    logic              s_arready;
    logic [ID_W-1:0]   s_rid;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic              s_rvalid;
    logic              s_rready;

    axi_mem_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .areset(areset),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t      exp_b[$];
    r_exp_t      exp_r[$];
    logic [31:0] model [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          toggle_mode = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s actual=no handshake required=handshake within budget at %0t", name, $time);
    endtask

    function automatic bit is_illegal(input logic [1:0] burst, input int len);
        return burst == 2'b11 || (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    // Address of beat i, from the burst rules stated as plain arithmetic.
    function automatic int unsigned beat_addr(input int unsigned addr, input logic [1:0] burst,
                                              input int len, input int i);
        int unsigned size, base;
        size = (len + 1) * 4;
        if (burst == 2'b00) return addr;
        if (burst == 2'b10) begin
            base = addr - (addr % size);
            return base + ((addr - base + i * 4) % size);
        end
        return addr + i * 4;
    endfunction

    initial begin
        s_bready = 1'b0;
        s_rready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            s_bready = 1'($urandom_range(0, 1));
            s_rready = toggle_mode ? !s_rready : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [31:0] prev_data;
        logic [1:0]  prev_resp;
        logic        prev_last;
        bit          stalled;
        b_exp_t      eb;
        r_exp_t      er;
        stalled = 1'b0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                chk("r_stall_valid", s_rvalid, 1);
                chk("r_stall_data", s_rdata, prev_data);
                chk("r_stall_resp", s_rresp, prev_resp);
                chk("r_stall_last", s_rlast, prev_last);
            end
            stalled   = s_rvalid && !s_rready;
            prev_data = s_rdata;
            prev_resp = s_rresp;
            prev_last = s_rlast;
            if (s_bvalid && s_bready) begin
                if (exp_b.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL b_unexpected actual=bvalid required=no response pending");
                end else begin
                    eb = exp_b.pop_front();
                    chk("bid", s_bid, eb.id);
                    chk("bresp", s_bresp, eb.resp);
                end
            end
            if (s_rvalid && s_rready) begin
                if (exp_r.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL r_unexpected actual=rvalid required=no beat pending");
                end else begin
                    er = exp_r.pop_front();
                    chk("rid", s_rid, er.id);
                    chk("rdata", s_rdata, er.data);
                    chk("rresp", s_rresp, er.resp);
                    chk("rlast", s_rlast, er.last);
                end
            end
        end
    end

    task automatic chk_reset_state();
        chk("rst_awready", s_awready, 1);
        chk("rst_arready", s_arready, 1);
        chk("rst_wready", s_wready, 0);
        chk("rst_bvalid", s_bvalid, 0);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_rlast", s_rlast, 0);
        chk("rst_bresp", s_bresp, 0);
        chk("rst_rresp", s_rresp, 0);
        chk("rst_bid", s_bid, 0);
        chk("rst_rid", s_rid, 0);
        chk("rst_rdata", s_rdata, 0);
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst);
        int t;
        @(posedge aclk);
        #1;
        s_awvalid = 1'b1;
        s_awid    = id;
        s_awaddr  = addr;
        s_awlen   = 8'(len);
        s_awburst = burst;
        t = 0;
        @(negedge aclk);
        while (!s_awready && t < 100) begin
            @(negedge aclk);
            t++;
        end
        if (!s_awready) timeout("aw_timeout");
        @(posedge aclk);
        #1;
        s_awvalid = 1'b0;
    endtask

    task automatic send_w(input int i, input bit last);
        int t;
        s_wvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge aclk);
            #1;
        end
        s_wvalid = 1'b1;
        s_wdata  = wd[i];
        s_wstrb  = ws[i];
        s_wlast  = last;
        t = 0;
        @(negedge aclk);
        while (!s_wready && t < 100) begin
            @(negedge aclk);
            t++;
        end
        if (!s_wready) timeout("w_timeout");
        @(posedge aclk);
        #1;
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input bit bad_last);
        bit          ill, err;
        int unsigned idx;
        int          t;
        b_exp_t      e;
        ill = is_illegal(burst, len);
        err = ill || bad_last;
        for (int i = 0; i <= len; i++) begin
            idx = beat_addr(addr, burst, len, i) / 4;
            if (idx >= DEPTH) err = 1'b1;
            else if (!ill)
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) model[idx][b*8 +: 8] = wd[i][b*8 +: 8];
        end
        e.id   = id;
        e.resp = err ? 2'b10 : 2'b00;
        exp_b.push_back(e);
        send_aw(id, addr, len, burst);
        for (int i = 0; i <= len; i++) send_w(i, bad_last ? (i != len) : (i == len));
        t = 0;
        while (exp_b.size() != 0 && t < 200) begin
            @(negedge aclk);
            t++;
        end
        if (exp_b.size() != 0) begin
            timeout("b_timeout");
            exp_b.delete();
        end
        @(negedge aclk);
        chk("awready_after_b", s_awready, 1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst);
        bit          ill, err;
        int unsigned idx;
        int          t;
        r_exp_t      e;
        ill = is_illegal(burst, len);
        for (int i = 0; i <= len; i++) begin
            idx    = beat_addr(addr, burst, len, i) / 4;
            err    = ill || idx >= DEPTH;
            e.id   = id;
            e.data = err ? 32'h0 : model[idx];
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (i == len);
            exp_r.push_back(e);
        end
        @(posedge aclk);
        #1;
        s_arvalid = 1'b1;
        s_arid    = id;
        s_araddr  = addr;
        s_arlen   = 8'(len);
        s_arburst = burst;
        t = 0;
        @(negedge aclk);
        while (!s_arready && t < 100) begin
            @(negedge aclk);
            t++;
        end
        if (!s_arready) timeout("ar_timeout");
        @(posedge aclk);
        #1;
        s_arvalid = 1'b0;
        @(negedge aclk);
        chk("r_first_valid", s_rvalid, 1);
        chk("arready_busy", s_arready, 0);
        t = 0;
        while (exp_r.size() != 0 && t < 1000) begin
            @(negedge aclk);
            t++;
        end
        if (exp_r.size() != 0) begin
            timeout("r_timeout");
            exp_r.delete();
        end
        @(negedge aclk);
        chk("arready_after_r", s_arready, 1);
    endtask

    task automatic rand_req(output logic [31:0] addr, output int len, output logic [1:0] burst);
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) begin
            burst = 2'b11;
            len   = $urandom_range(0, 7);
        end else if (r <= 2) begin
            burst = 2'b00;
            len   = $urandom_range(0, 7);
        end else if (r <= 6) begin
            burst = 2'b01;
            len   = $urandom_range(0, 15);
        end else begin
            burst = 2'b10;
            case ($urandom_range(0, 4))
                0: len = 1;
                1: len = 3;
                2: len = 7;
                3: len = 15;
                default: len = 2;
            endcase
        end
        addr = 32'($urandom_range(0, DEPTH + 3)) * 4;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=still running required=finished");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          len;
        logic [1:0]  burst;
        int          t;

        #2;
        areset = 1'b1;
        #1;
        chk_reset_state();
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        chk("wready_idle", s_wready, 0);

        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 32'h0;
            wd[i]    = $urandom;
            ws[i]    = 4'hF;
        end
        do_write(4'h1, 32'h0, DEPTH - 1, 2'b01, 1'b0);

        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'hdeadbeef + 32'(i);
            ws[i] = 4'hF;
        end
        do_write(4'h3, 32'h10, 3, 2'b01, 1'b0);
        toggle_mode = 1'b1;
        do_read(4'h6, 32'h10, 3, 2'b01);
        toggle_mode = 1'b0;

        for (int i = 0; i < 4; i++) begin
            wd[i] = $urandom;
            ws[i] = 4'hF;
        end
        do_write(4'h7, 32'h18, 3, 2'b10, 1'b0);
        wd[0] = 32'hFFFFFFFF;
        ws[0] = 4'h3;
        do_write(4'h8, 32'h10, 0, 2'b01, 1'b0);
        do_read(4'h9, 32'h10, 3, 2'b01);

        for (int i = 0; i < 3; i++) begin
            wd[i] = 32'(i + 1);
            ws[i] = 4'hF;
        end
        do_write(4'hA, 32'h20, 2, 2'b00, 1'b0);
        do_read(4'hB, 32'h20, 0, 2'b01);

        do_read(4'hC, 32'((DEPTH - 2) * 4), 3, 2'b01);
        for (int i = 0; i < 2; i++) begin
            wd[i] = $urandom;
            ws[i] = 4'hF;
        end
        do_write(4'hD, 32'h30, 1, 2'b11, 1'b0);
        do_read(4'hE, 32'h30, 1, 2'b01);
        do_read(4'h2, 32'h30, 2, 2'b10);
        do_write(4'h4, 32'h50, 1, 2'b01, 1'b1);
        do_read(4'h5, 32'h50, 1, 2'b01);

        for (int i = 0; i < 4; i++) begin
            wd[i] = $urandom;
            ws[i] = 4'hF;
        end
        send_aw(4'h5, 32'h40, 3, 2'b01);
        send_w(0, 1'b0);
        send_w(1, 1'b0);
        model[16] = wd[0];
        model[17] = wd[1];
        s_wvalid = 1'b1;
        s_wdata  = wd[2];
        #2;
        areset = 1'b1;
        #1;
        chk_reset_state();
        s_wvalid = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        t = exp_b.size() + exp_r.size();
        chk("queues_empty_at_reset", t, 0);
        do_read(4'h1, 32'h40, 3, 2'b01);
        for (int i = 0; i < 4; i++) wd[i] = $urandom;
        do_write(4'h6, 32'h60, 3, 2'b01, 1'b0);
        do_read(4'h7, 32'h60, 3, 2'b01);

        for (int n = 0; n < 25; n++) begin
            rand_req(a, len, burst);
            for (int i = 0; i <= len; i++) begin
                wd[i] = $urandom;
                ws[i] = 4'($urandom_range(0, 15));
            end
            do_write(4'($urandom_range(0, 15)), a, len, burst, $urandom_range(0, 9) == 0);
            rand_req(a, len, burst);
            do_read(4'($urandom_range(0, 15)), a, len, burst);
        end

        repeat (4) @(negedge aclk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
